inst_fetch_queue: RTL and testbench

Instruction fetch stage for the pipelined MIPS core: generates sequential byte-addressed fetch PCs, issues one-at-a-time requests to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small FIFO. It presents them to the CPU's decode input (`i_datain`) under a valid/ready handshake. Branch and jump resolution in decode drives `redirect`, which flushes the queue and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/inst_fetch_queue.sv | 126 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t  request-tracking states of the fetch FSM
//   PC_STEP        byte increment between sequential instructions
//   DEFAULT_*      default address / instruction widths of the MIPS core
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,   // no request outstanding
        WAIT,   // request outstanding, returned word will be queued
        DROP    // request outstanding, returned word will be discarded
    } fetch_state_t;

    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned DEFAULT_ADDR_W = 16;
    localparam int unsigned DEFAULT_DATA_W = 32;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} pairs with a registered head.
//   clock, reset     clock and synchronous active-high reset
//   flush            empties the FIFO; overrides push and pop
//   push, pushPc,
//   pushData         write one entry at the tail
//   pop              remove the head entry (ignored when empty)
//   valid            FIFO holds at least one entry
//   headPc, headData head entry; holds its last value while empty
//   count            current occupancy, 0..DEPTH
module fetch_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        pushPc,
    input  logic [DATA_W-1:0]        pushData,
    input  logic                     pop,
    output logic                     valid,
    output logic [ADDR_W-1:0]        headPc,
    output logic [DATA_W-1:0]        headData,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          headQ, headNext;
    logic [PtrW-1:0] rdPtr, wrPtr, rdPtrNext;
    logic [CntW-1:0] countRemain, countNext;
    logic            pushEff, popEff;

    assign pushEff = push && !flush;
    assign popEff  = pop && !flush && (count != '0);

    assign rdPtrNext   = rdPtr + PtrW'(popEff);
    assign countRemain = count - CntW'(popEff);
    assign countNext   = countRemain + CntW'(pushEff);

    // The head register tracks whichever entry will sit at the read pointer after
    // this cycle; a push into an (effectively) empty FIFO bypasses the array.
    always_comb begin
        headNext = headQ;
        if (countRemain != '0) begin
            headNext = mem[rdPtrNext];
        end else if (pushEff) begin
            headNext = '{pc: pushPc, instr: pushData};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            headQ <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtrNext;
            wrPtr <= wrPtr + PtrW'(pushEff);
            count <= countNext;
            headQ <= headNext;
        end
    end

    always_ff @(posedge clock) begin
        if (pushEff) begin
            mem[wrPtr] <= '{pc: pushPc, instr: pushData};
        end
    end

    assign valid    = (count != '0);
    assign headPc   = headQ.pc;
    assign headData = headQ.instr;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch stage of the pipelined MIPS core.
//   clock, reset          clock and synchronous active-high reset
//   redirect, redirect_pc taken branch/jump from decode: flush and refetch
//   imem_req, imem_addr   one-at-a-time request to instruction memory
//   imem_ack, imem_rdata  memory accept + returned word (same cycle)
//   i_datain, i_pc        head instruction and its PC towards decode
//   i_valid, i_ready      decode handshake; head consumed when both high
//   count                 current queue occupancy
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_ack,
    input  logic [DATA_W-1:0]      imem_rdata,
    output logic [DATA_W-1:0]      i_datain,
    output logic [ADDR_W-1:0]      i_pc,
    output logic                   i_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fetch_state_t      st, stNext;
    logic [ADDR_W-1:0] fetchPc, fetchPcNext;
    logic [ADDR_W-1:0] addrQ, addrNext;
    logic              push, pop;
    logic [CntW-1:0]   countAfter;
    logic              slotFree;
    logic              unusedRedirectLsbs;

    // Redirect wins over push and pop: the whole queue is flushed anyway.
    assign push = (st == WAIT) && imem_ack && !redirect;
    assign pop  = i_valid && i_ready && !redirect;

    // A new request reserves a slot, so it may only issue while the post-update
    // occupancy leaves room for the word it will bring back.
    assign countAfter = count + CntW'(push) - CntW'(pop);
    assign slotFree   = countAfter < CntW'(DEPTH);

    always_comb begin
        stNext      = st;
        fetchPcNext = fetchPc;
        addrNext    = addrQ;
        if (redirect) begin
            fetchPcNext = {redirect_pc[ADDR_W-1:2], 2'b00};
            // An unacknowledged request must still complete; its data is dropped.
            if (st != IDLE && !imem_ack) begin
                stNext = DROP;
            end else begin
                stNext = IDLE;
            end
        end else begin
            case (st)
                IDLE: begin
                    if (slotFree) begin
                        stNext   = WAIT;
                        addrNext = fetchPc;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        fetchPcNext = fetchPc + ADDR_W'(PC_STEP);
                        if (slotFree) begin
                            addrNext = fetchPc + ADDR_W'(PC_STEP);
                        end else begin
                            stNext = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        stNext = IDLE;
                    end
                end
                default: stNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= IDLE;
            fetchPc <= '0;
            addrQ   <= '0;
        end else begin
            st      <= stNext;
            fetchPc <= fetchPcNext;
            addrQ   <= addrNext;
        end
    end

    assign imem_req  = (st != IDLE);
    assign imem_addr = addrQ;

    // Word alignment is forced, so the two low redirect bits are never used.
    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect),
        .push     (push),
        .pushPc   (fetchPc),
        .pushData (imem_rdata),
        .pop      (pop),
        .valid    (i_valid),
        .headPc   (i_pc),
        .headData (i_datain),
        .count    (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed and randomized stimulus for inst_fetch_queue,
// checked every cycle against a queue-based reference model.
module tb_inst_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] i_datain;
    logic [15:0] i_pc;
    logic        i_valid;
    logic        i_ready = 1'b0;
    logic [2:0]  count;

    inst_fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .i_datain    (i_datain),
        .i_pc        (i_pc),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .count       (count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] data;
    } ent_t;

    // Reference model: queued words, next fetch PC, outstanding request info.
    ent_t        q[$];
    ent_t        mHead;
    logic [15:0] mPc;
    logic [15:0] mAddr;
    bit          mOut;
    bit          mDrop;

    int nCmp = 0;
    int nErr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mHead = '0;
        mPc   = '0;
        mAddr = '0;
        mOut  = 0;
        mDrop = 0;
    endtask

    task automatic checkOutputs();
        ent_t h;
        h = (q.size() > 0) ? q[0] : mHead;
        check("imem_req",  32'(imem_req),  32'(mOut));
        check("imem_addr", 32'(imem_addr), 32'(mAddr));
        check("i_valid",   32'(i_valid),   32'(q.size() > 0));
        check("count",     32'(count),     32'(q.size()));
        check("i_pc",      32'(i_pc),      32'(h.pc));
        check("i_datain",  i_datain,       h.data);
    endtask

    // One clock cycle: check outputs, drive inputs, clock edge, advance model.
    task automatic step(input bit ack, input bit rdy, input bit redir,
                        input logic [15:0] rpc, input bit rst);
        bit          a;
        bit          popNow;
        logic [31:0] rd;
        checkOutputs();
        a           = ack && mOut;
        rd          = $urandom;
        imem_ack    = a;
        imem_rdata  = rd;
        i_ready     = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        reset       = rst;
        @(posedge clock);
        if (rst) begin
            modelReset();
        end else if (redir) begin
            q.delete();
            mPc = {rpc[15:2], 2'b00};
            if (mOut && !a) begin
                mDrop = 1;
            end else begin
                mOut  = 0;
                mDrop = 0;
            end
        end else begin
            popNow = (q.size() > 0) && rdy;
            if (popNow) void'(q.pop_front());
            if (a) begin
                if (mDrop) begin
                    mOut  = 0;
                    mDrop = 0;
                end else begin
                    q.push_back('{pc: mAddr, data: rd});
                    mPc = mAddr + 16'd4;
                    if (q.size() < DEPTH) mAddr = mPc;
                    else mOut = 0;
                end
            end else if (!mOut && q.size() < DEPTH) begin
                mOut  = 1;
                mAddr = mPc;
            end
        end
        if (q.size() > 0) mHead = q[0];
        @(negedge clock);
        imem_ack = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic doReset();
        step(0, 0, 0, 16'h0, 1);
    endtask

    initial begin
        // Power-up reset: outputs are X until the first reset edge.
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelReset();

        // Reset values.
        check("rst_req",   32'(imem_req),  32'h0);
        check("rst_addr",  32'(imem_addr), 32'h0);
        check("rst_valid", 32'(i_valid),   32'h0);
        check("rst_count", 32'(count),     32'h0);
        check("rst_pc",    32'(i_pc),      32'h0);
        check("rst_data",  i_datain,       32'h0);

        // Streaming: ack every cycle, decode always ready.
        for (int i = 0; i < 14; i++) step(1, 1, 0, 16'h0, 0);

        // Backpressure: fill to DEPTH, then drain.
        doReset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0, 0);
        check("full_count", 32'(count),    32'd4);
        check("full_req",   32'(imem_req), 32'd0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 16'h0, 0);

        // Slow memory: ack every third cycle.
        doReset();
        for (int i = 0; i < 18; i++) step(i % 3 == 2, 1'($urandom_range(0, 1)), 0, 16'h0, 0);

        // Redirect while request to 0x0008 is pending.
        doReset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 0);
        check("pend_addr", 32'(imem_addr), 32'h0008);
        step(0, 0, 1, 16'h0123, 0);
        check("drop_state", 32'(dut.st), 32'(DROP));
        step(1, 0, 0, 16'h0, 0);
        step(0, 0, 0, 16'h0, 0);
        check("redir_addr", 32'(imem_addr), 32'h0120);
        check("redir_req",  32'(imem_req),  32'h1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h0, 0);

        // Redirect coinciding with ack, two entries queued.
        doReset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 0);
        check("pre_count", 32'(count), 32'd2);
        step(1, 0, 1, 16'h0040, 0);
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        check("redir_head", 32'(i_pc), 32'h0040);

        // Wrap at the top of the address space, then reset mid-WAIT.
        step(0, 1, 1, 16'hFFF8, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0, 0);
        check("wait_state", 32'(dut.st), 32'(WAIT));
        doReset();
        check("mid_req",   32'(imem_req),  32'h0);
        check("mid_addr",  32'(imem_addr), 32'h0);
        check("mid_valid", 32'(i_valid),   32'h0);
        check("mid_count", 32'(count),     32'h0);
        check("mid_pc",    32'(i_pc),      32'h0);
        check("mid_data",  i_datain,       32'h0);

        // Randomized mix of acks, backpressure, redirects and resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 99) == 0);
        end
        checkOutputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
